// File: rtl/common.sv
// Shared types for the formula loader and DB_kernel: literal, clause and
// formula containers, their size limits, and the loader state encoding.
package common;

  localparam int MAX_CLAUSES = 10;
  localparam int MAX_LITS    = 5;
  localparam int CIDX_W      = $clog2(MAX_CLAUSES + 1);
  localparam int LIDX_W      = $clog2(MAX_LITS + 1);

  typedef logic [CIDX_W-1:0] cidx_t;
  typedef logic [LIDX_W-1:0] lidx_t;

  // A literal is a variable number (1..7; 0 is illegal) and a polarity bit.
  typedef struct packed {
    logic [2:0] var_id;
    logic       pol;
  } lit;

  typedef struct packed {
    lit [MAX_LITS-1:0] lits;
    lidx_t             count;
  } clause;

  typedef struct packed {
    clause [MAX_CLAUSES-1:0] clauses;
    cidx_t                   count;
  } formula;

  localparam lit zero_lit = '0;

  typedef enum logic [1:0] {
    LOAD,
    SOLVE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/loader_watchdog.sv
// Solve-phase cycle counter; expire flags the last allowed cycle so the
// loader can abort on the following edge.
module loader_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable && !expire) begin
      timer <= timer + 1'b1;
    end
  end

  assign expire = enable && (timer == TW'(TIMEOUT - 1));

endmodule

// File: rtl/formula_loader.sv
// Assembles a host literal stream into a formula, runs DB_kernel on it under
// a watchdog, and holds the verdict for the host until acknowledged.
module formula_loader
  import common::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   in_valid,
  output logic   in_ready,
  input  lit     in_lit,
  input  logic   in_eoc,
  input  logic   in_eof,
  output logic   kernel_reset,
  output logic   kernel_find,
  output formula kernel_formula,
  input  logic   kernel_ended,
  input  logic   kernel_sat,
  input  logic   kernel_unsat,
  output logic   done,
  output logic   result_sat,
  output logic   result_unsat,
  output logic   error,
  input  logic   ack
);

  loader_state_t state, state_nxt;
  formula        buf_q;
  cidx_t         cidx;
  lidx_t         lidx;
  logic          beat, beat_err, clause_end, expire;

  assign beat       = in_valid && in_ready;
  assign clause_end = in_eoc || in_eof;
  // Any of these drops the beat: illegal var, formula full, clause full.
  assign beat_err   = (in_lit.var_id == 3'd0)
                   || (cidx == cidx_t'(MAX_CLAUSES))
                   || (lidx == lidx_t'(MAX_LITS));

  loader_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .clear (state != SOLVE),
    .enable(state == SOLVE),
    .expire(expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  // NOTE: assign a default before the case so every path drives state_nxt;
  // a missing branch would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: begin
        if (beat && beat_err)    state_nxt = DONE;
        else if (beat && in_eof) state_nxt = SOLVE;
      end
      SOLVE: begin
        if (kernel_ended || expire) state_nxt = DONE;
      end
      DONE: begin
        if (ack) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready     = (state == LOAD);
    kernel_find  = (state == SOLVE);
    kernel_reset = (state != SOLVE);
    done         = (state == DONE);
  end

  // NOTE: the buffer is a register bank, not a RAM, and is reset so the
  // kernel never sees undefined clause data after power-up.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_q        <= '0;
      cidx         <= '0;
      lidx         <= '0;
      result_sat   <= 1'b0;
      result_unsat <= 1'b0;
      error        <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (beat && beat_err) begin
            error <= 1'b1;
          end else if (beat) begin
            buf_q.clauses[cidx].lits[lidx] <= in_lit;
            if (clause_end) begin
              buf_q.clauses[cidx].count <= lidx + 1'b1;
              cidx <= cidx + 1'b1;
              lidx <= '0;
              if (in_eof) buf_q.count <= cidx + 1'b1;
            end else begin
              lidx <= lidx + 1'b1;
            end
          end
        end
        SOLVE: begin
          // A verdict in the same cycle as expiry takes priority.
          if (kernel_ended) begin
            result_sat   <= kernel_sat;
            result_unsat <= kernel_unsat;
          end else if (expire) begin
            error <= 1'b1;
          end
        end
        DONE: begin
          if (ack) begin
            buf_q        <= '0;
            cidx         <= '0;
            lidx         <= '0;
            result_sat   <= 1'b0;
            result_unsat <= 1'b0;
            error        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign kernel_formula = buf_q;

endmodule

// File: tb/tb_formula_loader.sv
// Directed bench for formula_loader: a scoreboard of expected verdicts is
// drained by a monitor on each rising done; a TIMEOUT=16 twin checks the watchdog.
module tb_formula_loader;
  import common::*;

  logic   clock, reset;
  logic   in_valid, in_eoc, in_eof, ack;
  lit     in_lit;
  logic   kernel_ended, kernel_sat, kernel_unsat;
  logic   in_ready, kernel_reset, kernel_find, done, result_sat, result_unsat, error;
  formula kernel_formula;
  logic   w_in_ready, w_kernel_reset, w_kernel_find, w_done;
  logic   w_result_sat, w_result_unsat, w_error;
  formula w_kernel_formula;

  formula_loader #(.TIMEOUT(4096)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_lit(in_lit), .in_eoc(in_eoc), .in_eof(in_eof),
    .kernel_reset(kernel_reset), .kernel_find(kernel_find),
    .kernel_formula(kernel_formula), .kernel_ended(kernel_ended),
    .kernel_sat(kernel_sat), .kernel_unsat(kernel_unsat), .done(done),
    .result_sat(result_sat), .result_unsat(result_unsat), .error(error), .ack(ack)
  );

  formula_loader #(.TIMEOUT(16)) dut16 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_lit(in_lit), .in_eoc(in_eoc), .in_eof(in_eof),
    .kernel_reset(w_kernel_reset), .kernel_find(w_kernel_find),
    .kernel_formula(w_kernel_formula), .kernel_ended(kernel_ended),
    .kernel_sat(kernel_sat), .kernel_unsat(kernel_unsat), .done(w_done),
    .result_sat(w_result_sat), .result_unsat(w_result_unsat), .error(w_error), .ack(ack)
  );

  typedef struct {
    logic sat;
    logic unsat;
    logic err;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  int     find_cnt = 0;
  int     fc;
  formula exp_f;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic s, input logic u, input logic e);
    exp_t x;
    x.sat = s; x.unsat = u; x.err = e;
    sb.push_back(x);
  endtask

  // Monitor: verdict comparison on each rising done, plus per-cycle invariants.
  initial begin : monitor
    logic done_q;
    exp_t x;
    done_q = 1'b0;
    forever begin
      @(negedge clock);
      check("find_reset_exclusive", kernel_find & kernel_reset, 1'b0);
      if (kernel_find) find_cnt++;
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected_done: got done=1, want no pending verdict");
        end else begin
          x = sb.pop_front();
          check("sb_sat", result_sat, x.sat);
          check("sb_unsat", result_unsat, x.unsat);
          check("sb_error", error, x.err);
        end
      end
      done_q = done;
    end
  end

  // Drives one beat; entered and left at #1 after a rising edge.
  task automatic beat(input logic [3:0] l, input logic eoc, input logic eof);
    in_valid = 1'b1; in_lit = l; in_eoc = eoc; in_eof = eof;
    @(posedge clock); #1;
    in_valid = 1'b0; in_lit = '0; in_eoc = 1'b0; in_eof = 1'b0;
  endtask

  task automatic load_clause(input int k, input logic [19:0] l, input int n,
                             input logic eoc_last, input logic eof_last);
    exp_f.clauses[k].lits  = l;
    exp_f.clauses[k].count = lidx_t'(n);
    for (int i = 0; i < n; i++)
      beat(l[i*4 +: 4], (i == n-1) ? eoc_last : 1'b0, (i == n-1) ? eof_last : 1'b0);
    if (eof_last) exp_f.count = cidx_t'(k + 1);
  endtask

  // Kernel model: reports a verdict in SOLVE cycle 'delay' (cycle 0 = find rise).
  task automatic kernel_end(input int delay, input logic s, input logic u);
    repeat (delay) @(posedge clock);
    #1;
    kernel_ended = 1'b1; kernel_sat = s; kernel_unsat = u;
    check("done_not_early", done, 1'b0);
    @(posedge clock); #1;
    kernel_ended = 1'b0; kernel_sat = 1'b0; kernel_unsat = 1'b0;
    check("done_latency", done, 1'b1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clock); #1;
    ack = 1'b0;
    check("ack_done_clear", done, 1'b0);
    check("ack_error_clear", error, 1'b0);
    check("ack_sat_clear", result_sat, 1'b0);
    check("ack_unsat_clear", result_unsat, 1'b0);
    check("ack_in_ready", in_ready, 1'b1);
    check("ack_buffer_clear", kernel_formula, '0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_kernel_reset"}, kernel_reset, 1'b1);
    check({tag, "_kernel_find"}, kernel_find, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_sat"}, result_sat, 1'b0);
    check({tag, "_unsat"}, result_unsat, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_formula"}, kernel_formula, '0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_lit = '0; in_eoc = 1'b0; in_eof = 1'b0;
    ack = 1'b0; kernel_ended = 1'b0; kernel_sat = 1'b0; kernel_unsat = 1'b0;
    #12;
    check_reset_vals("por");
    reset = 1'b1;
    @(posedge clock); #1;

    // Full 10-clause formula; clause 9 = {3-} closed by eof alone.
    exp_f = '0;
    load_clause(0, 20'hB9753, 5, 1'b1, 1'b0);
    load_clause(1, 20'h00052, 2, 1'b1, 1'b0);
    load_clause(2, 20'h00074, 2, 1'b1, 1'b0);
    load_clause(3, 20'h00096, 2, 1'b1, 1'b0);
    load_clause(4, 20'h000B8, 2, 1'b1, 1'b0);
    load_clause(5, 20'h0003A, 2, 1'b1, 1'b0);
    load_clause(6, 20'h00062, 2, 1'b1, 1'b0);
    load_clause(7, 20'h00085, 2, 1'b1, 1'b0);
    load_clause(8, 20'h0002B, 2, 1'b1, 1'b0);
    check("full_find_before_eof", kernel_find, 1'b0);
    load_clause(9, 20'h00006, 1, 1'b0, 1'b1);
    check("full_find_latency", kernel_find, 1'b1);
    check("full_kernel_reset_low", kernel_reset, 1'b0);
    check("full_in_ready_low", in_ready, 1'b0);
    check("full_count", kernel_formula.count, 4'b1010);
    check("full_c9_count", kernel_formula.clauses[9].count, 3'b001);
    check("full_c9_slots", kernel_formula.clauses[9].lits[4:1], 16'h0000);
    check("full_formula", kernel_formula, exp_f);
    push_exp(1'b1, 1'b0, 1'b0);
    kernel_end(20, 1'b1, 1'b0);
    check("done_find_low", kernel_find, 1'b0);
    check("done_kernel_reset", kernel_reset, 1'b1);
    check("done_in_ready_low", in_ready, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("done_hold", done, 1'b1);
    check("done_hold_sat", result_sat, 1'b1);
    do_ack();

    // Single-clause runs back to back; buffer must not keep stale data.
    exp_f = '0;
    load_clause(0, 20'h00003, 1, 1'b1, 1'b1);
    check("run1_count", kernel_formula.count, 4'd1);
    check("run1_formula", kernel_formula, exp_f);
    ack = 1'b1;
    @(posedge clock); #1;
    ack = 1'b0;
    check("ack_ignored_in_solve", kernel_find, 1'b1);
    push_exp(1'b0, 1'b1, 1'b0);
    kernel_end(3, 1'b0, 1'b1);
    do_ack();
    exp_f = '0;
    load_clause(0, 20'h00002, 1, 1'b0, 1'b1);
    check("run2_count", kernel_formula.count, 4'd1);
    check("run2_formula", kernel_formula, exp_f);
    push_exp(1'b1, 1'b0, 1'b0);
    kernel_end(0, 1'b1, 1'b0);
    do_ack();

    // Six literals without eoc: sixth beat dropped, kernel never started.
    fc = find_cnt;
    exp_f = '0;
    exp_f.clauses[0].lits = 20'hB9753;
    for (int i = 0; i < 5; i++) beat(exp_f.clauses[0].lits[i], 1'b0, 1'b0);
    check("six_still_loading", in_ready, 1'b1);
    push_exp(1'b0, 1'b0, 1'b1);
    beat(4'h2, 1'b0, 1'b0);
    check("six_error", error, 1'b1);
    check("six_formula", kernel_formula, exp_f);
    @(negedge clock);
    check("six_find_never", find_cnt, fc);
    @(posedge clock); #1;
    do_ack();

    // Eleventh clause.
    exp_f = '0;
    for (int k = 0; k < 10; k++) begin
      exp_f.clauses[k].lits[0] = 4'h3;
      exp_f.clauses[k].count   = 3'd1;
      beat(4'h3, 1'b1, 1'b0);
    end
    check("ten_clauses_ok", error, 1'b0);
    check("ten_clauses_ready", in_ready, 1'b1);
    push_exp(1'b0, 1'b0, 1'b1);
    beat(4'h5, 1'b1, 1'b0);
    check("eleventh_error", error, 1'b1);
    check("eleventh_formula", kernel_formula, exp_f);
    do_ack();

    // Variable 0 literal, even when flagged as end of formula.
    exp_f = '0;
    exp_f.clauses[0].lits[0] = 4'h3;
    beat(4'h3, 1'b0, 1'b0);
    push_exp(1'b0, 1'b0, 1'b1);
    beat(4'h1, 1'b1, 1'b1);
    check("var0_error", error, 1'b1);
    check("var0_no_find", kernel_find, 1'b0);
    check("var0_formula", kernel_formula, exp_f);
    do_ack();

    // Verdict in the last watchdog cycle of the TIMEOUT=16 twin: verdict wins.
    push_exp(1'b1, 1'b0, 1'b0);
    beat(4'h3, 1'b1, 1'b1);
    kernel_end(15, 1'b1, 1'b0);
    check("coincide_done", w_done, 1'b1);
    check("coincide_error", w_error, 1'b0);
    check("coincide_sat", w_result_sat, 1'b1);
    do_ack();

    // Kernel never ends: twin aborts 16 cycles after find rises.
    beat(4'h3, 1'b1, 1'b1);
    check("to_find_rise", w_kernel_find, 1'b1);
    repeat (15) @(posedge clock);
    #1;
    check("to_error_not_early", w_error, 1'b0);
    check("to_find_held", w_kernel_find, 1'b1);
    @(posedge clock); #1;
    check("to_error", w_error, 1'b1);
    check("to_done", w_done, 1'b1);
    check("to_find_drop", w_kernel_find, 1'b0);
    check("to_sat_zero", w_result_sat, 1'b0);
    check("main_in_solve", kernel_find, 1'b1);

    // Reset mid-SOLVE (main) and mid-DONE (twin).
    #3 reset = 1'b0;
    #2;
    check_reset_vals("rst_solve");
    check("rst_twin_error", w_error, 1'b0);
    check("rst_twin_done", w_done, 1'b0);
    #2 reset = 1'b1;
    @(posedge clock); #1;

    // Reset mid-LOAD with gaps between beats and a beat pending.
    beat(4'h3, 1'b1, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    beat(4'h5, 1'b0, 1'b0);
    in_valid = 1'b1; in_lit = 4'h7;
    #3 reset = 1'b0;
    #2;
    check_reset_vals("rst_load");
    in_valid = 1'b0; in_lit = '0;
    #2 reset = 1'b1;
    @(posedge clock); #1;

    exp_f = '0;
    load_clause(0, 20'h00043, 2, 1'b1, 1'b1);
    check("reload_find", kernel_find, 1'b1);
    check("reload_formula", kernel_formula, exp_f);
    push_exp(1'b0, 1'b1, 1'b0);
    kernel_end(2, 1'b0, 1'b1);
    do_ack();

    @(negedge clock);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
